cfg_chain_loader: RTL

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_chain_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: loads a NUM_BITS configuration image from a stream of
// WORD_W-bit words, serialising each word LSB first into a shadow register,
// and commits the shadow to cfg_q in one step when the image is complete.
// Optional feature macro: CFG_PARITY_EN (per-word parity check, cfg_err).
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in LOAD and never depends on in_valid. The producer
// keeps in_data (and in_parity) stable while in_valid is high until that
// transfer edge.
module cfg_chain_loader #(
  parameter int NUM_BITS = 32,
  parameter int WORD_W   = 8,
  localparam int CNT_W   = $clog2(NUM_BITS + 1),
  localparam int SUB_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
`ifdef CFG_PARITY_EN
  input  logic                in_parity,
  output logic                cfg_err,
`endif
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] cfg_q,
  output logic                cfg_valid,
  output logic [1:0]          dbg_state_o,
  output logic [CNT_W-1:0]    dbg_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [NUM_BITS-1:0] cfg_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                done_q, done_d;
`ifdef CFG_PARITY_EN
  logic                word_err_q, word_err_d;
  logic                cfg_err_q, cfg_err_d;
`endif

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      sub_q       <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef CFG_PARITY_EN
      word_err_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
`ifdef CFG_PARITY_EN
      word_err_q  <= word_err_d;
      cfg_err_q   <= cfg_err_d;
`endif
    end
  end

  // Next-state logic: IDLE waits for start, LOAD accepts one word, SHIFT
  // moves it bit by bit into the shadow and commits on the last bit.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    done_d      = 1'b0;
`ifdef CFG_PARITY_EN
    word_err_d  = word_err_q;
    cfg_err_d   = cfg_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_LOAD;
          shadow_d = '0;
          cnt_d    = '0;
          sub_d    = '0;
`ifdef CFG_PARITY_EN
          word_err_d = 1'b0;
          cfg_err_d  = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d  = S_IDLE;
          shadow_d = '0;
        end else if (in_valid) begin
          word_d  = in_data;
          sub_d   = '0;
          state_d = S_SHIFT;
`ifdef CFG_PARITY_EN
          if (^{in_data, in_parity}) word_err_d = 1'b1;
`endif
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d  = S_IDLE;
          shadow_d = '0;
        end else begin
          shadow_d = {word_q[0], shadow_q[NUM_BITS-1:1]};
          word_d   = word_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          sub_d    = sub_q + SUB_W'(1);
          if (cnt_q == CNT_W'(NUM_BITS - 1)) begin
            // Last bit: the whole image is in shadow_d, publish it atomically.
            state_d = S_IDLE;
`ifdef CFG_PARITY_EN
            if (word_err_q) begin
              cfg_err_d = 1'b1;
            end else begin
              cfg_d       = shadow_d;
              cfg_valid_d = 1'b1;
              done_d      = 1'b1;
            end
`else
            cfg_d       = shadow_d;
            cfg_valid_d = 1'b1;
            done_d      = 1'b1;
`endif
          end else if (sub_q == SUB_W'(WORD_W - 1)) begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign cfg_valid   = cfg_valid_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;
`ifdef CFG_PARITY_EN
  assign cfg_err     = cfg_err_q;
`endif

endmodule
